// File: rtl/pc_pkg.sv
`default_nettype none
// pc_pkg: shared encodings for the program-counter unit (rev 1.0).
package pc_pkg;

  typedef logic [2:0] pc_sel_t;

  localparam pc_sel_t PC_SEQ    = 3'd0;
  localparam pc_sel_t PC_BRANCH = 3'd1;
  localparam pc_sel_t PC_JALR   = 3'd2;
  localparam pc_sel_t PC_TRAP   = 3'd3;
  localparam pc_sel_t PC_MRET   = 3'd4;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam int unsigned PC_INC = 4;

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// pc_next_calc: combinational next-PC target and alignment check (rev 1.0).
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int IALIGN16 = 0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] offset_addr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] trap_vec,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] jalr_sum;
  logic            checked;

  assign jalr_sum = rs1_val + offset_addr;

  always_comb begin
    target  = pc + XLEN'(PC_INC);
    checked = 1'b0;
    case (pc_sel)
      PC_BRANCH: begin
        target  = pc + (offset_addr << 1);
        checked = 1'b1;
      end
      PC_JALR: begin
        target  = jalr_sum & ~XLEN'(1);
        checked = 1'b1;
      end
      PC_TRAP: target = trap_vec & ~XLEN'(3);
      PC_MRET: begin
        target  = epc;
        checked = 1'b1;
      end
      default: target = pc + XLEN'(PC_INC);
    endcase
  end

  // Bit0 is always even here, so only bit1 can break 4-byte alignment.
  assign misaligned = checked && target[1] && (IALIGN16 == 0);

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// pc_unit: program counter with traps, MRET, halt/resume FSM and retire counter (rev 1.0).
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 32,
  parameter int              IALIGN16     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       pc_sel,
  input  logic [XLEN-1:0]  offset_addr,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  instruction_ptr,
  output logic [XLEN-1:0]  epc,
  output logic [XLEN-1:0]  bad_addr,
  output logic             misalign_exc,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  logic [0:0]      state;
  logic [0:0]      state_next;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic [XLEN-1:0] trap_base;
  logic            is_trap;

  pc_next_calc #(
    .XLEN     (XLEN),
    .IALIGN16 (IALIGN16)
  ) u_calc (
    .pc          (instruction_ptr),
    .pc_sel      (pc_sel),
    .offset_addr (offset_addr),
    .rs1_val     (rs1_val),
    .trap_vec    (trap_vec),
    .epc         (epc),
    .target      (target),
    .misaligned  (misaligned)
  );

  assign trap_base = trap_vec & ~XLEN'(3);
  assign is_trap   = (pc_sel == PC_TRAP);
  assign halted    = (state == ST_HALT);

  // A trap always lands in RUN; misaligned redirects leave the FSM alone.
  always_comb begin
    state_next = state;
    if (is_trap) begin
      state_next = ST_RUN;
    end else if (state == ST_RUN) begin
      if (halt_req) state_next = ST_HALT;
    end else begin
      if (resume && !halt_req) state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_ptr <= RESET_VECTOR;
      epc             <= '0;
      bad_addr        <= '0;
      misalign_exc    <= 1'b0;
      retired_count   <= '0;
      state           <= ST_RUN;
    end else begin
      misalign_exc <= 1'b0;
      state        <= state_next;
      if (is_trap) begin
        instruction_ptr <= trap_base;
        epc             <= instruction_ptr;
      end else if (misaligned) begin
        instruction_ptr <= trap_base;
        epc             <= instruction_ptr;
        bad_addr        <= target;
        misalign_exc    <= 1'b1;
      end else if ((state == ST_RUN) && !stall) begin
        instruction_ptr <= target;
        retired_count   <= retired_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// tb_pc_unit: directed plan plus randomized run, checked against a spec-level model.
module tb_pc_unit;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  epc;
    logic [XLEN-1:0]  bad;
    logic             exc;
    logic             halted;
    logic [CNT_W-1:0] cnt;
  } st_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      pc_sel;
  logic [XLEN-1:0] offset_addr, rs1_val, trap_vec;
  logic            stall, halt_req, resume;

  logic [XLEN-1:0]  ip   [2];
  logic [XLEN-1:0]  epc  [2];
  logic [XLEN-1:0]  bad  [2];
  logic             exc  [2];
  logic             hlt  [2];
  logic [CNT_W-1:0] cnt  [2];

  st_t m [2];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(XLEN), .RESET_VECTOR('0), .CNT_W(CNT_W), .IALIGN16(0)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .offset_addr(offset_addr),
    .rs1_val(rs1_val), .trap_vec(trap_vec), .stall(stall), .halt_req(halt_req),
    .resume(resume), .instruction_ptr(ip[0]), .epc(epc[0]), .bad_addr(bad[0]),
    .misalign_exc(exc[0]), .halted(hlt[0]), .retired_count(cnt[0]));

  pc_unit #(.XLEN(XLEN), .RESET_VECTOR('0), .CNT_W(CNT_W), .IALIGN16(1)) dut16 (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .offset_addr(offset_addr),
    .rs1_val(rs1_val), .trap_vec(trap_vec), .stall(stall), .halt_req(halt_req),
    .resume(resume), .instruction_ptr(ip[1]), .epc(epc[1]), .bad_addr(bad[1]),
    .misalign_exc(exc[1]), .halted(hlt[1]), .retired_count(cnt[1]));

  function automatic st_t observed(int k);
    return {ip[k], epc[k], bad[k], exc[k], hlt[k], cnt[k]};
  endfunction

  function automatic st_t reset_state();
    st_t s;
    s = '0;
    return s;
  endfunction

  // One clock edge of architectural behaviour, straight from the rules.
  function automatic st_t mstep(st_t s, bit ialign16);
    st_t n;
    logic [XLEN-1:0] t, tv;
    bit chk, mis;
    n = s;
    n.exc = 1'b0;
    tv = {trap_vec[XLEN-1:2], 2'b00};
    chk = 1'b1;
    case (pc_sel)
      3'd1:    t = s.pc + offset_addr * 2;
      3'd2:    begin t = rs1_val + offset_addr; t[0] = 1'b0; end
      3'd3:    begin t = tv; chk = 1'b0; end
      3'd4:    t = s.epc;
      default: begin t = s.pc + 4; chk = 1'b0; end
    endcase
    mis = chk && t[1] && !ialign16;
    if (pc_sel == 3'd3) begin
      n.pc = tv; n.epc = s.pc; n.halted = 1'b0;
    end else begin
      if (mis) begin
        n.pc = tv; n.epc = s.pc; n.bad = t; n.exc = 1'b1;
      end else if (!s.halted && !stall) begin
        n.pc = t; n.cnt = s.cnt + 1;
      end
      if (!s.halted && halt_req) n.halted = 1'b1;
      else if (s.halted && resume && !halt_req) n.halted = 1'b0;
    end
    return n;
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [XLEN-1:0] off,
                       input logic [XLEN-1:0] r1, input logic [XLEN-1:0] tv,
                       input logic st, input logic hr, input logic rs);
    pc_sel = sel; offset_addr = off; rs1_val = r1; trap_vec = tv;
    stall = st; halt_req = hr; resume = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) m[k] = mstep(m[k], k == 1);
    #1;
  endtask

  task automatic goto_pc(input logic [XLEN-1:0] a);
    drive(3'd2, '0, a, 64'h800, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m[k] = reset_state();
      checks++;
      if (observed(k) !== m[k]) begin
        failures++;
        $display("FAIL reset dut%0d got=%h want=%h", k, observed(k), m[k]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_seq();
    logic [XLEN-1:0] want;
    for (int i = 1; i <= 5; i++) begin
      drive(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      want = XLEN'(4 * i);
      checks++;
      if (ip[0] !== want) begin
        failures++;
        $display("FAIL seq_pc step%0d got=%h want=%h", i, ip[0], want);
      end
    end
    checks++;
    if (cnt[0] !== CNT_W'(5)) begin
      failures++;
      $display("FAIL seq_count got=%0d want=5", cnt[0]);
    end
  endtask

  task automatic test_branch();
    goto_pc(64'h20);
    drive(3'd1, 64'h10, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ip[0] !== 64'h40) begin
      failures++;
      $display("FAIL branch_fwd got=%h want=40", ip[0]);
    end
    drive(3'd1, -64'sd8, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ip[0] !== 64'h30) begin
      failures++;
      $display("FAIL branch_back got=%h want=30", ip[0]);
    end
  endtask

  task automatic test_misalign();
    logic [CNT_W-1:0] c0;
    goto_pc(64'h100);
    c0 = cnt[0];
    drive(3'd2, '0, 64'h2003, 64'h800, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({ip[0], exc[0], bad[0], epc[0], cnt[0]} !== {64'h800, 1'b1, 64'h2002, 64'h100, c0}) begin
      failures++;
      $display("FAIL misalign pc=%h exc=%b bad=%h epc=%h cnt=%0d want pc=800 exc=1 bad=2002 epc=100 cnt=%0d",
               ip[0], exc[0], bad[0], epc[0], cnt[0], c0);
    end
    checks++;
    if ({ip[1], exc[1]} !== {64'h2002, 1'b0}) begin
      failures++;
      $display("FAIL ialign16_jalr pc=%h exc=%b want pc=2002 exc=0", ip[1], exc[1]);
    end
    drive(3'd0, '0, '0, 64'h800, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (exc[0] !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse got=%b want=0", exc[0]);
    end
  endtask

  task automatic test_trap_mret();
    goto_pc(64'h44);
    drive(3'd3, '0, '0, 64'h803, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({ip[0], epc[0]} !== {64'h800, 64'h44}) begin
      failures++;
      $display("FAIL trap pc=%h epc=%h want pc=800 epc=44", ip[0], epc[0]);
    end
    drive(3'd4, '0, '0, 64'h803, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ip[0] !== 64'h44) begin
      failures++;
      $display("FAIL mret got=%h want=44", ip[0]);
    end
  endtask

  task automatic test_halt_stall();
    logic [CNT_W-1:0] c0;
    goto_pc(64'h10);
    drive(3'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({ip[0], hlt[0]} !== {64'h14, 1'b1}) begin
      failures++;
      $display("FAIL halt_enter pc=%h halted=%b want pc=14 halted=1", ip[0], hlt[0]);
    end
    c0 = cnt[0];
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checks++;
    if ({ip[0], cnt[0]} !== {64'h14, c0}) begin
      failures++;
      $display("FAIL halt_hold pc=%h cnt=%0d want pc=14 cnt=%0d", ip[0], cnt[0], c0);
    end
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if ({ip[0], hlt[0]} !== {64'h14, 1'b0}) begin
      failures++;
      $display("FAIL resume pc=%h halted=%b want pc=14 halted=0", ip[0], hlt[0]);
    end
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ip[0] !== 64'h18) begin
      failures++;
      $display("FAIL after_resume got=%h want=18", ip[0]);
    end
    c0 = cnt[0];
    drive(3'd1, 64'h40, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    checks++;
    if ({ip[0], cnt[0]} !== {64'h18, c0}) begin
      failures++;
      $display("FAIL stall_hold pc=%h cnt=%0d want pc=18 cnt=%0d", ip[0], cnt[0], c0);
    end
  endtask

  task automatic test_async_reset_wrap();
    goto_pc(64'h8FC);
    drive(3'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({ip[0], hlt[0]} !== {64'h900, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset pc=%h halted=%b want pc=900 halted=1", ip[0], hlt[0]);
    end
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) m[k] = reset_state();
    checks++;
    if ({ip[0], hlt[0], cnt[0]} !== {64'h0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL async_reset pc=%h halted=%b cnt=%0d want pc=0 halted=0 cnt=0", ip[0], hlt[0], cnt[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ip[0] !== 64'h0) begin
      failures++;
      $display("FAIL seq_wrap got=%h want=0", ip[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      drive(3'($urandom_range(0, 7)),
            (i % 3 == 0) ? {$urandom, $urandom} : {{32{r[31]}}, r},
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (observed(k) !== m[k]) begin
          failures++;
          $display("FAIL random%0d dut%0d got=%h want=%h", i, k, observed(k), m[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_misalign();
    test_trap_mret();
    test_halt_stall();
    test_async_reset_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
